// File: rtl/bus_pkg.sv
// Shared definitions for the device-side bus port: default field widths,
// per-cycle event flags, and small helpers for address decode and counters.
package bus_pkg;

    localparam int         ID_W_DEF      = 8;
    localparam int         PCKG_SZ_DEF   = 16;
    localparam logic [7:0] BROADCAST_DEF = 8'hFF;

    // One flag per countable event in a single cycle.
    typedef struct packed {
        logic tx_ovf;
        logic rx_ovf;
        logic misroute;
        logic pop_err;
    } port_evt_t;

    // Destination ID is the top id_w bits of a pkt_w-bit packet.
    // The packet is passed zero-extended so one function serves any width up to 64.
    function automatic logic [31:0] get_dest(input logic [63:0] pkt, input int pkt_w, input int id_w);
        logic [63:0] mask;
        mask = (64'd1 << id_w) - 64'd1;
        return 32'((pkt >> (pkt_w - id_w)) & mask);
    endfunction

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/bus_sync_fifo.sv
// Single-clock FIFO with first-word fall-through head.
// A push while full is taken when a pop retires the head in the same cycle.
module bus_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // full implies non-empty, so a same-cycle pop always frees the slot
    assign do_push = push & (~full | do_pop);
    // Head reads zero when empty so stale storage never leaks out.
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage needs no reset; it is only observed through the gated head.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bus_dev_port.sv
// Device endpoint of the shared bus: TX queue toward the arbiter, address-filtered
// RX queue from the arbiter, saturating event counters and a sticky pop error.
module bus_dev_port
    import bus_pkg::*;
#(
    parameter int              PCKG_SZ   = PCKG_SZ_DEF,
    parameter int              ID_W      = ID_W_DEF,
    parameter int              DEPTH     = 8,
    parameter int              DEV_ID    = 0,
    parameter logic [ID_W-1:0] BROADCAST = ID_W'(BROADCAST_DEF)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [PCKG_SZ-1:0] wr_data,
    output logic               tx_full,
    output logic               pndng,
    output logic [PCKG_SZ-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [PCKG_SZ-1:0] D_push,
    input  logic               rd_en,
    output logic [PCKG_SZ-1:0] rd_data,
    output logic               rx_valid,
    output logic [7:0]         tx_ovf_cnt,
    output logic [7:0]         rx_ovf_cnt,
    output logic [7:0]         misroute_cnt,
    output logic               pop_err
);

    logic        tx_empty, rx_empty, rx_full;
    logic [31:0] dest;
    logic        addr_ok, rx_push;
    port_evt_t   evt;

    assign dest    = get_dest(64'(D_push), PCKG_SZ, ID_W);
    assign addr_ok = (dest == 32'(DEV_ID)) | (dest == 32'(BROADCAST));
    assign rx_push = push & addr_ok;

    bus_sync_fifo #(.WIDTH(PCKG_SZ), .DEPTH(DEPTH)) u_tx (
        .clk   (clk),
        .rst_n (reset),
        .push  (wr_en),
        .din   (wr_data),
        .pop   (pop),
        .head  (D_pop),
        .empty (tx_empty),
        .full  (tx_full)
    );

    bus_sync_fifo #(.WIDTH(PCKG_SZ), .DEPTH(DEPTH)) u_rx (
        .clk   (clk),
        .rst_n (reset),
        .push  (rx_push),
        .din   (D_push),
        .pop   (rd_en),
        .head  (rd_data),
        .empty (rx_empty),
        .full  (rx_full)
    );

    assign pndng    = ~tx_empty;
    assign rx_valid = ~rx_empty;

    // Classify this cycle's drop/error events from the pre-edge queue state.
    always_comb begin
        evt          = '0;
        evt.tx_ovf   = wr_en & tx_full & ~pop;
        evt.rx_ovf   = rx_push & rx_full & ~rd_en;
        evt.misroute = push & ~addr_ok;
        evt.pop_err  = pop & tx_empty;
    end

    // Saturating event counters and the sticky pop error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_ovf_cnt   <= '0;
            rx_ovf_cnt   <= '0;
            misroute_cnt <= '0;
            pop_err      <= 1'b0;
        end else begin
            if (evt.tx_ovf)   tx_ovf_cnt   <= sat_inc8(tx_ovf_cnt);
            if (evt.rx_ovf)   rx_ovf_cnt   <= sat_inc8(rx_ovf_cnt);
            if (evt.misroute) misroute_cnt <= sat_inc8(misroute_cnt);
            if (evt.pop_err)  pop_err      <= 1'b1;
        end
    end

endmodule
